// File: rtl/dff_bank_arbiter.sv
// -----------------------------------------------------------------------------
// dff_bank_arbiter
//
// Shares one WIDTH-bit register bank among four requesters. A round-robin
// arbiter picks one requester per transaction. A two-state FSM (IDLE/EXEC)
// then applies that requester's operation to the bank. Each transaction takes
// two clock cycles:
//   edge 1 (IDLE->EXEC) : latch winner index, opcode and data; raise grant/busy
//   edge 2 (EXEC->IDLE) : update q, pulse ack, advance the round-robin pointer
//
// Ports
//   clk      : system clock, rising edge active
//   reset_n  : asynchronous active-low reset
//   req[3:0] : request per requester
//   op[7:0]  : 2-bit opcode per requester, op[2i+1:2i]
//              (00 load, 01 set-all, 10 clear-all, 11 no-op)
//   wdata    : load data per requester, wdata[WIDTH*i +: WIDTH]
//   grant    : one-hot owner of the transaction in EXEC, zero in IDLE
//   ack      : one-cycle one-hot completion pulse, coincident with new q
//   busy     : high while in EXEC
//   owner    : index of the most recently granted requester
//   q        : bank contents
// All outputs are registered.
// -----------------------------------------------------------------------------
module dff_bank_arbiter #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [3:0]         req,
    input  logic [7:0]         op,
    input  logic [4*WIDTH-1:0] wdata,
    output logic [3:0]         grant,
    output logic [3:0]         ack,
    output logic               busy,
    output logic [1:0]         owner,
    output logic [WIDTH-1:0]   q
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    state_t             state_r;
    logic [1:0]         rr_ptr_r;
    logic [1:0]         win_idx_r;
    logic [1:0]         win_op_r;
    logic [WIDTH-1:0]   win_data_r;
    logic [3:0]         grant_r;
    logic [3:0]         ack_r;
    logic               busy_r;
    logic [1:0]         owner_r;
    logic [WIDTH-1:0]   q_r;

    logic               found_s;
    logic [1:0]         pick_s;
    logic [1:0]         cand_s;
    logic [1:0]         sel_op_s;
    logic [WIDTH-1:0]   sel_data_s;

    // One-hot encoding of a requester index.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] v;
        case (idx)
            2'd0:    v = 4'b0001;
            2'd1:    v = 4'b0010;
            2'd2:    v = 4'b0100;
            2'd3:    v = 4'b1000;
            default: v = 4'b0000;
        endcase
        return v;
    endfunction

    // Bank value after applying an opcode to the current contents.
    function automatic logic [WIDTH-1:0] apply_op(input logic [WIDTH-1:0] cur,
                                                  input logic [1:0]       opc,
                                                  input logic [WIDTH-1:0] data);
        logic [WIDTH-1:0] v;
        case (opc)
            OP_LOAD:  v = data;
            OP_SET:   v = {WIDTH{1'b1}};
            OP_CLEAR: v = {WIDTH{1'b0}};
            default:  v = cur;
        endcase
        return v;
    endfunction

    // Round-robin scan: the first set req bit at or after rr_ptr (mod 4) wins.
    always_comb begin
        found_s = 1'b0;
        pick_s  = rr_ptr_r;
        cand_s  = rr_ptr_r;
        for (int k = 0; k < 4; k++) begin
            cand_s = rr_ptr_r + 2'(k);
            if (!found_s && req[cand_s]) begin
                found_s = 1'b1;
                pick_s  = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Opcode and data slice of the current round-robin candidate.
    always_comb begin
        sel_op_s   = op[{pick_s, 1'b0} +: 2];
        sel_data_s = wdata[WIDTH*int'(pick_s) +: WIDTH];
    end

    // Transaction FSM; it owns the bank and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= 2'd0;
            win_idx_r  <= 2'd0;
            win_op_r   <= 2'b11;
            win_data_r <= {WIDTH{1'b0}};
            grant_r    <= 4'b0000;
            ack_r      <= 4'b0000;
            busy_r     <= 1'b0;
            owner_r    <= 2'd0;
            q_r        <= RESET_VAL;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // ack from the previous transaction lasts exactly one cycle
                    ack_r <= 4'b0000;
                    if (found_s) begin
                        win_idx_r  <= pick_s;
                        win_op_r   <= sel_op_s;
                        win_data_r <= sel_data_s;
                        grant_r    <= onehot4(pick_s);
                        owner_r    <= pick_s;
                        busy_r     <= 1'b1;
                        state_r    <= ST_EXEC;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    // Uses only the values latched at grant; live inputs are ignored.
                    q_r      <= apply_op(q_r, win_op_r, win_data_r);
                    ack_r    <= onehot4(win_idx_r);
                    grant_r  <= 4'b0000;
                    busy_r   <= 1'b0;
                    rr_ptr_r <= win_idx_r + 2'd1;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    grant_r <= 4'b0000;
                    ack_r   <= 4'b0000;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant = grant_r;
    assign ack   = ack_r;
    assign busy  = busy_r;
    assign owner = owner_r;
    assign q     = q_r;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dff_bank_arbiter
//
// Bench for dff_bank_arbiter. The reference model works at transaction level.
// The winner is the first requester found scanning from the pointer modulo 4.
// The bank value follows the opcode semantics. The pointer becomes
// winner+1 mod 4. Inputs are driven and outputs sampled on the falling edge.
// Each snapshot is {grant, ack, busy, owner, q}.
// -----------------------------------------------------------------------------
module tb_dff_bank_arbiter;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'h5A;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [31:0] wdata;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic        busy;
    logic [1:0]  owner;
    logic [7:0]  q;

    int          n_checks = 0;
    int          n_err    = 0;

    // reference model state
    logic [7:0]  m_q;
    int          m_ptr;
    int          m_owner;
    logic [1:0]  m_op  [4];
    logic [7:0]  m_dat [4];

    logic [18:0] obs;
    logic [18:0] exp_v;

    dff_bank_arbiter #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .op      (op),
        .wdata   (wdata),
        .grant   (grant),
        .ack     (ack),
        .busy    (busy),
        .owner   (owner),
        .q       (q)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] snap();
        return {grant, ack, busy, owner, q};
    endfunction

    function automatic int model_winner(input logic [3:0] r, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (r[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_apply(input logic [7:0] cur,
                                               input logic [1:0] o,
                                               input logic [7:0] d);
        case (o)
            2'b00:   return d;
            2'b01:   return 8'hFF;
            2'b10:   return 8'h00;
            default: return cur;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input int i, input logic [1:0] o, input logic [7:0] d);
        req[i]        = 1'b1;
        op[2*i +: 2]  = o;
        wdata[8*i +: 8] = d;
        m_op[i]       = o;
        m_dat[i]      = d;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        req = 4'b0000; op = 8'h00; wdata = 32'h0;
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        obs = snap(); exp_v = {4'b0000, 4'b0000, 1'b0, 2'd0, RV};
        if (obs !== exp_v) begin
            n_err++; $display("FAIL reset_async: got %h want %h", obs, exp_v);
        end
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        m_q = RV; m_ptr = 0; m_owner = 0;
        tick();
        n_checks++;
        obs = snap(); exp_v = {4'b0000, 4'b0000, 1'b0, 2'd0, RV};
        if (obs !== exp_v) begin
            n_err++; $display("FAIL reset_idle: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_single_load();
        drive(0, 2'b00, 8'hA5);
        tick();
        n_checks++;
        obs = snap(); exp_v = {4'b0001, 4'b0000, 1'b1, 2'd0, m_q};
        if (obs !== exp_v) begin
            n_err++; $display("FAIL load_grant: got %h want %h", obs, exp_v);
        end
        tick();
        m_q = 8'hA5; m_ptr = 1; m_owner = 0;
        n_checks++;
        obs = snap(); exp_v = {4'b0000, 4'b0001, 1'b0, 2'd0, 8'hA5};
        if (obs !== exp_v) begin
            n_err++; $display("FAIL load_ack: got %h want %h", obs, exp_v);
        end
        req = 4'b0000;
        tick();
        n_checks++;
        obs = snap(); exp_v = {4'b0000, 4'b0000, 1'b0, 2'd0, 8'hA5};
        if (obs !== exp_v) begin
            n_err++; $display("FAIL load_ack_once: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_set_clear();
        drive(2, 2'b01, 8'h00);
        tick();
        n_checks++;
        obs = snap(); exp_v = {4'b0100, 4'b0000, 1'b1, 2'd2, m_q};
        if (obs !== exp_v) begin
            n_err++; $display("FAIL set_grant: got %h want %h", obs, exp_v);
        end
        tick();
        n_checks++;
        obs = snap(); exp_v = {4'b0000, 4'b0100, 1'b0, 2'd2, 8'hFF};
        if (obs !== exp_v) begin
            n_err++; $display("FAIL set_ack: got %h want %h", obs, exp_v);
        end
        // req stays high through ack: treated as a fresh request
        drive(2, 2'b10, 8'h00);
        tick();
        tick();
        n_checks++;
        obs = snap(); exp_v = {4'b0000, 4'b0100, 1'b0, 2'd2, 8'h00};
        if (obs !== exp_v) begin
            n_err++; $display("FAIL clear_ack: got %h want %h", obs, exp_v);
        end
        req = 4'b0000;
        m_q = 8'h00; m_ptr = 3; m_owner = 2;
        tick();
    endtask

    task automatic test_rr_sweep();
        // fresh reset so the scan starts from requester 0
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        m_q = RV; m_ptr = 0; m_owner = 0;
        for (int i = 0; i < 4; i++) drive(i, 2'b00, 8'h10 + 8'(i));
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (grant !== 4'(1 << (k % 4)) || busy !== 1'b1) begin
                n_err++; $display("FAIL rr_grant[%0d]: got grant=%b busy=%b want grant=%b", k, grant, busy, 4'(1 << (k % 4)));
            end
            tick();
            n_checks++;
            if (q !== 8'h10 + 8'(k % 4) || ack !== 4'(1 << (k % 4))) begin
                n_err++; $display("FAIL rr_ack[%0d]: got q=%h ack=%b want q=%h ack=%b", k, q, ack, 8'h10 + 8'(k % 4), 4'(1 << (k % 4)));
            end
            if (k == 3) begin
                n_checks++;
                if (q !== 8'h13) begin
                    n_err++; $display("FAIL rr_after4: got %h want 13", q);
                end
            end
        end
        req = 4'b0000;
        m_q = 8'h10; m_ptr = 1; m_owner = 0;
        tick();
    endtask

    task automatic test_rotation();
        drive(1, 2'b11, 8'hEE);
        tick();
        tick();
        m_ptr = 2; m_owner = 1;
        n_checks++;
        obs = snap(); exp_v = {4'b0000, 4'b0010, 1'b0, 2'd1, m_q};
        if (obs !== exp_v) begin
            n_err++; $display("FAIL rot_noop: got %h want %h", obs, exp_v);
        end
        req = 4'b0000;
        drive(0, 2'b10, 8'h00);
        drive(3, 2'b00, 8'h77);
        tick();
        n_checks++;
        obs = snap(); exp_v = {4'b1000, 4'b0000, 1'b1, 2'd3, m_q};
        if (obs !== exp_v) begin
            n_err++; $display("FAIL rot_first: got %h want %h", obs, exp_v);
        end
        tick();
        req[3] = 1'b0;
        tick();
        n_checks++;
        obs = snap(); exp_v = {4'b0001, 4'b0000, 1'b1, 2'd0, 8'h77};
        if (obs !== exp_v) begin
            n_err++; $display("FAIL rot_second: got %h want %h", obs, exp_v);
        end
        tick();
        req = 4'b0000;
        m_q = 8'h00; m_ptr = 1; m_owner = 0;
        n_checks++;
        obs = snap(); exp_v = {4'b0000, 4'b0001, 1'b0, 2'd0, 8'h00};
        if (obs !== exp_v) begin
            n_err++; $display("FAIL rot_clear: got %h want %h", obs, exp_v);
        end
        tick();
    endtask

    task automatic test_abort();
        drive(1, 2'b00, 8'h3C);
        tick();
        #2 reset_n = 1'b0;
        #1;
        m_q = RV; m_ptr = 0; m_owner = 0;
        n_checks++;
        obs = snap(); exp_v = {4'b0000, 4'b0000, 1'b0, 2'd0, RV};
        if (obs !== exp_v) begin
            n_err++; $display("FAIL abort_async: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        reset_n = 1'b1;
        n_checks++;
        obs = snap();
        if (obs !== exp_v) begin
            n_err++; $display("FAIL abort_no_ack: got %h want %h", obs, exp_v);
        end
        tick();
        n_checks++;
        obs = snap(); exp_v = {4'b0010, 4'b0000, 1'b1, 2'd1, RV};
        if (obs !== exp_v) begin
            n_err++; $display("FAIL abort_regrant: got %h want %h", obs, exp_v);
        end
        tick();
        m_q = 8'h3C; m_ptr = 2; m_owner = 1;
        n_checks++;
        obs = snap(); exp_v = {4'b0000, 4'b0010, 1'b0, 2'd1, 8'h3C};
        if (obs !== exp_v) begin
            n_err++; $display("FAIL abort_done: got %h want %h", obs, exp_v);
        end
        req = 4'b0000;
        tick();
    endtask

    // Random requesters that hold until acked; the winner scrambles its
    // inputs (and may drop req) during EXEC, which must have no effect.
    task automatic test_random();
        logic [3:0] pend;
        int         w;
        pend = 4'b0000;
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && ($urandom_range(9) < 4)) begin
                    pend[i] = 1'b1;
                    drive(i, 2'($urandom_range(3)), 8'($urandom));
                end
            end
            req = pend;
            w = model_winner(pend, m_ptr);
            if (w < 0) begin
                tick();
                n_checks++;
                obs = snap(); exp_v = {4'b0000, 4'b0000, 1'b0, 2'(m_owner), m_q};
                if (obs !== exp_v) begin
                    n_err++; $display("FAIL rnd_idle[%0d]: got %h want %h", t, obs, exp_v);
                end
            end else begin
                tick();
                m_owner = w;
                n_checks++;
                obs = snap(); exp_v = {4'(1 << w), 4'b0000, 1'b1, 2'(w), m_q};
                if (obs !== exp_v) begin
                    n_err++; $display("FAIL rnd_grant[%0d]: got %h want %h", t, obs, exp_v);
                end
                op[2*w +: 2]    = 2'($urandom_range(3));
                wdata[8*w +: 8] = 8'($urandom);
                req[w]          = 1'($urandom_range(1));
                tick();
                m_q   = model_apply(m_q, m_op[w], m_dat[w]);
                m_ptr = (w + 1) % 4;
                n_checks++;
                obs = snap(); exp_v = {4'b0000, 4'(1 << w), 1'b0, 2'(w), m_q};
                if (obs !== exp_v) begin
                    n_err++; $display("FAIL rnd_ack[%0d]: got %h want %h", t, obs, exp_v);
                end
                pend[w] = 1'b0;
                req = pend;
            end
        end
        req = 4'b0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_set_clear();
        test_rr_sweep();
        test_rotation();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Shares one WIDTH-bit D-flip-flop register bank among 4 requesters.
- Each requester asks for one of four operations: load, set-all, clear-all, or no-op.
- A round-robin arbiter picks one requester per transaction, and a 2-state FSM applies its operation to the bank. Each transaction takes two cycles.
- The block sits between the requesting stimulus/control logic and the bank. The bank is held internally and exposed on q.

Parameters:
- WIDTH, 8, bit width of the shared register bank.
- RESET_VAL, 0, value loaded into q on reset (WIDTH bits).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; req[i] belongs to requester i.
- op  input  8  2-bit opcode per requester, op[2i+1:2i]. 00=load, 01=set-all, 10=clear-all, 11=no-op.
- wdata  input  4*WIDTH  load data per requester, wdata[WIDTH*i +: WIDTH].
- grant  output  4  one-hot; identifies the requester currently in EXEC. All zero in IDLE.
- ack  output  4  one-cycle completion pulse, one-hot.
- busy  output  1  high while the FSM is in EXEC.
- owner  output  2  index of the last granted requester.
- q  output  WIDTH  current bank contents.

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-low (clk, reset_n).
  - While reset_n=0, all outputs are forced immediately, independent of clk: q=RESET_VAL, grant=0, ack=0, busy=0, owner=0, rr_ptr=0, state=IDLE.
- Registered outputs: all outputs are registered; there are no combinational input-to-output paths.
- FSM states: IDLE and EXEC.
- IDLE:
  - If req==0, stay in IDLE; q holds.
  - Otherwise pick a winner by round-robin: scan req starting at index rr_ptr and ascending modulo 4; the first set bit wins.
  - On the next edge, latch the winner's index, opcode and wdata slice. Set grant to one-hot(winner), set owner=winner, set busy=1, and go to EXEC.
- EXEC (always exactly one cycle): on the next edge:
  - Apply the latched opcode to q:
    - load: q = latched wdata.
    - set-all: q = all ones.
    - clear-all: q = all zeros.
    - no-op: q unchanged.
  - Pulse ack[winner]=1 for this one cycle.
  - Clear grant to 0 and busy to 0.
  - Set rr_ptr = (winner+1) mod 4, wrapping 3 to 0.
  - Return to IDLE.
- Latency:
  - A req seen in IDLE at edge N gets grant after edge N and q updated plus ack after edge N+1.
  - Maximum throughput is one transaction per 2 cycles.
  - ack and the new q value become visible in the same cycle.
- Handshake:
  - A requester holds req, op and wdata until it sees its ack.
  - Changes to req, op or wdata during EXEC are ignored, because the values were latched at grant.
  - If req is dropped during EXEC, the transaction still completes and ack is still issued.
  - A requester that still has req high in the cycle ack is asserted is treated as a new request and arbitrates normally in IDLE.
- Fairness: with all 4 requesters continuously asserted, grants rotate 0,1,2,3,0,... Any requester waits at most 3 transactions (6 cycles) for its grant.
- Boundary conditions:
  - Simultaneous requests are resolved only by rr_ptr; there is no fixed priority.
  - Reset during EXEC aborts the transaction: q=RESET_VAL, no ack is emitted, and after release the FSM resumes in IDLE with rr_ptr=0.
  - Reset release is used synchronously at the next clk edge.

Test Plan:
- Reset: assert reset_n=0 mid-cycle (not on an edge) -> q=RESET_VAL, busy=0, grant=0 immediately, without waiting for clk.
- Single load: WIDTH=8, req=0001, op[1:0]=00, wdata[7:0]=8'hA5 -> grant=0001 for 1 cycle, then q=8'hA5 with ack=0001 for exactly 1 cycle.
- Set then clear: requester 2 issues op=01 (set-all) -> q=8'hFF with ack=0100. Then requester 2 issues op=10 (clear-all) -> q=8'h00.
- Round-robin sweep: req=1111 held, each requester i doing a load of value 8'h10+i -> grant order 0,1,2,3,0 on every second cycle; after 4 transactions q=8'h13 and rr_ptr has wrapped to 0.
- Priority rotation: requester 1 completes a transaction, then req=1001 is applied -> requester 3 is granted before requester 0, since the scan starts at rr_ptr=2.
- Abort: reset_n pulsed low during EXEC of a load of 8'h3C -> no ack, q=RESET_VAL. After release, the held req is re-arbitrated and completes with q=8'h3C.
